router_input_vc_buf: RTL and testbench

//  Router input-port buffer. It sits directly downstream of the PE injection FIFO, or of an

---
 rtl/router_input_vc_buf_pkg.sv | 27 ++
 rtl/router_input_vc_buf_vc_fifo.sv | 63 ++++++
 rtl/router_input_vc_buf.sv | 107 ++++++++++
 tb/tb_router_input_vc_buf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_input_vc_buf_pkg.sv
// Shared types and widths for the router input VC buffer.
// Flit layout: type field at [TYPE_MSB:TYPE_LSB], payload above it.
package router_input_vc_buf_pkg;

  localparam int DATAW    = 31;
  localparam int VCHW     = 0;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'b00,
    FLIT_BODY     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'b00,
    VC_ROUTE  = 2'b01,
    VC_ACTIVE = 2'b10
  } vc_state_e;

  function automatic logic is_head(logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/router_input_vc_buf_vc_fifo.sv
// Single-VC circular flit buffer.
// Ports: clk, rst_, wr_en, rd_en, din, dout (head), nxt_type, count, full, empty.
module router_input_vc_buf_vc_fifo
  import router_input_vc_buf_pkg::*;
#(
  parameter int W     = DATAW + 1,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [1:0]    nxt_type,
  output logic [PTRW:0] count,
  output logic          full,
  output logic          empty
);

  localparam int CW = PTRW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] rd_inc;

  assign rd_inc = rd_ptr + PTRW'(1);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTRW'(1);
      if (rd_en) rd_ptr <= rd_inc;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Type of the flit that will sit at the head after this edge,
  // so the VC FSM can enter ROUTE in the same cycle it appears.
  always_comb begin
    nxt_type = mem[rd_ptr][TYPE_MSB:TYPE_LSB];
    if (rd_en) begin
      if (count > CW'(1)) nxt_type = mem[rd_inc][TYPE_MSB:TYPE_LSB];
      else                nxt_type = din[TYPE_MSB:TYPE_LSB];
    end else if (count == '0) begin
      nxt_type = din[TYPE_MSB:TYPE_LSB];
    end
  end

endmodule

// File: rtl/router_input_vc_buf.sv
// Router input port: per-VC flit FIFOs, packet FSMs and credit return.
// Ports: clk, rst_, idata/ivalid/ivch in, grt pops; odata/ovalid/oreq/ocredit/ovf out.
module router_input_vc_buf
  import router_input_vc_buf_pkg::*;
#(
  parameter int NVC   = 2,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [DATAW:0]            idata,
  input  logic                      ivalid,
  input  logic [VCHW:0]             ivch,
  input  logic [NVC-1:0]            grt,
  output logic [NVC*(DATAW+1)-1:0]  odata,
  output logic [NVC-1:0]            ovalid,
  output logic [NVC-1:0]            oreq,
  output logic [NVC-1:0]            ocredit,
  output logic                      ovf
);

  localparam int W  = DATAW + 1;
  localparam int CW = PTRW + 1;

  logic [NVC-1:0] wsel;
  logic [NVC-1:0] wr;
  logic [NVC-1:0] pop;
  logic [NVC-1:0] full;
  logic [NVC-1:0] empty;
  logic [NVC-1:0] drop;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    logic [W-1:0]  dout;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    nxt_type;
    logic [1:0]    head_type;
    vc_state_e     state_q;
    vc_state_e     state_d;
    vc_state_e     after_pop;

    assign wsel[v] = ivalid && (int'(ivch) == v);
    assign pop[v]  = grt[v] && !empty[v];
    // A full VC still accepts a write when it pops in the same cycle.
    assign wr[v]   = wsel[v] && (!full[v] || pop[v]);
    assign drop[v] = wsel[v] && full[v] && !pop[v];

    router_input_vc_buf_vc_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .PTRW  (PTRW)
    ) u_fifo (
      .clk      (clk),
      .rst_     (rst_),
      .wr_en    (wr[v]),
      .rd_en    (pop[v]),
      .din      (idata),
      .dout     (dout),
      .nxt_type (nxt_type),
      .count    (count),
      .full     (full[v]),
      .empty    (empty[v])
    );

    assign odata[v*W +: W] = dout;
    assign ovalid[v]       = !empty[v];
    assign oreq[v]         = (state_q == VC_ROUTE);
    assign head_type       = dout[TYPE_MSB:TYPE_LSB];
    assign cnt_nxt         = count + CW'(wr[v]) - CW'(pop[v]);

    always_ff @(posedge clk or posedge rst_) begin
      if (rst_) state_q <= VC_IDLE;
      else      state_q <= state_d;
    end

    // Pop transitions first, then a lookahead on the next head so
    // a freshly exposed head flit requests routing with no bubble.
    always_comb begin
      after_pop = state_q;
      if (pop[v]) begin
        unique case (state_q)
          VC_ROUTE:
            if (head_type == FLIT_HEAD) after_pop = VC_ACTIVE;
            else                        after_pop = VC_IDLE;
          VC_ACTIVE:
            if (head_type == FLIT_TAIL) after_pop = VC_IDLE;
          default: after_pop = VC_IDLE;
        endcase
      end
      state_d = after_pop;
      if (after_pop == VC_IDLE && cnt_nxt != '0 && is_head(nxt_type))
        state_d = VC_ROUTE;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ocredit <= '0;
      ovf     <= 1'b0;
    end else begin
      ocredit <= pop;
      ovf     <= ovf | (|drop);
    end
  end

endmodule

// File: tb/tb_router_input_vc_buf.sv
// Directed plus random bench for router_input_vc_buf.
// Reference: per-VC queues with a packet-in-progress flag.
module tb_router_input_vc_buf;

  localparam int NVC   = 2;
  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic              clk;
  logic              rst_;
  logic [W-1:0]      idata;
  logic              ivalid;
  logic [0:0]        ivch;
  logic [NVC-1:0]    grt;
  logic [NVC*W-1:0]  odata;
  logic [NVC-1:0]    ovalid;
  logic [NVC-1:0]    oreq;
  logic [NVC-1:0]    ocredit;
  logic              ovf;

  router_input_vc_buf #(
    .NVC   (NVC),
    .DEPTH (DEPTH),
    .PTRW  (2)
  ) dut (
    .clk     (clk),
    .rst_    (rst_),
    .idata   (idata),
    .ivalid  (ivalid),
    .ivch    (ivch),
    .grt     (grt),
    .odata   (odata),
    .ovalid  (ovalid),
    .oreq    (oreq),
    .ocredit (ocredit),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq [NVC][$];
  bit           mid [NVC];
  bit           m_ovf;
  logic [1:0]   m_cred;
  int           cred_cnt [NVC];
  bit           gen_mid [NVC];
  int           gen_nb [NVC];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_hd(logic [1:0] t);
    return (t == 2'b00) || (t == 2'b11);
  endfunction

  task automatic check_all();
    logic [W-1:0] h;
    logic         e;
    for (int v = 0; v < NVC; v++) begin
      e = 1'b0;
      if (mq[v].size() > 0) begin
        h = mq[v][0];
        e = !mid[v] && is_hd(h[1:0]);
        check($sformatf("odata%0d", v), odata[v*W +: W], h);
      end
      check($sformatf("ovalid%0d", v), ovalid[v], mq[v].size() > 0);
      check($sformatf("oreq%0d", v), oreq[v], e);
      check($sformatf("ocredit%0d", v), ocredit[v], m_cred[v]);
      if (ocredit[v]) cred_cnt[v]++;
    end
    check("ovf", ovf, m_ovf);
  endtask

  task automatic model_clear();
    for (int v = 0; v < NVC; v++) begin
      mq[v].delete();
      mid[v]     = 1'b0;
      gen_mid[v] = 1'b0;
      gen_nb[v]  = 0;
    end
    m_cred = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic cycle(input logic iv, input int ch,
                       input logic [W-1:0] d,
                       input logic [1:0] g);
    logic [1:0]   p;
    logic [W-1:0] f;
    ivalid = iv;
    ivch   = ch[0];
    idata  = d;
    grt    = g;
    for (int v = 0; v < NVC; v++) begin
      p[v] = g[v] && (mq[v].size() > 0);
      if (p[v]) begin
        f = mq[v].pop_front();
        if (!mid[v]) begin
          if (f[1:0] == 2'b00) mid[v] = 1'b1;
        end else if (f[1:0] == 2'b10) begin
          mid[v] = 1'b0;
        end
      end
    end
    if (iv) begin
      if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
      else                       m_ovf = 1'b1;
    end
    m_cred = p;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_ = 1'b1;
    #1;
    check("rst_async_ovalid", ovalid, 0);
    check("rst_async_oreq", oreq, 0);
    check("rst_async_ocredit", ocredit, 0);
    model_clear();
    ivalid = 1'b0;
    grt    = '0;
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_ = 1'b0;
  endtask

  task automatic gen_flit(input int v, output logic [W-1:0] d);
    logic [31:0] r;
    logic [1:0]  t;
    r = $urandom();
    if (!gen_mid[v]) begin
      if ($urandom_range(0, 2) == 0) begin
        t = 2'b11;
      end else begin
        t          = 2'b00;
        gen_mid[v] = 1'b1;
        gen_nb[v]  = $urandom_range(0, 2);
      end
    end else if (gen_nb[v] > 0) begin
      t = 2'b01;
      gen_nb[v]--;
    end else begin
      t          = 2'b10;
      gen_mid[v] = 1'b0;
    end
    d = {r[31:2], t};
  endtask

  initial begin
    logic [W-1:0] d;
    logic [1:0]   g;
    logic         iv;
    int           ch;

    rst_   = 1'b1;
    ivalid = 1'b0;
    ivch   = '0;
    idata  = '0;
    grt    = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    rst_ = 1'b0;

    // 1: single HEADTAIL through VC0
    cycle(1, 0, 32'h0000_00A3, 2'b00);
    check("t1_ovalid", ovalid, 2'b01);
    check("t1_oreq", oreq, 2'b01);
    check("t1_odata", odata[W-1:0], 32'h0000_00A3);
    cycle(0, 0, 0, 2'b01);
    check("t1_ovalid_pop", ovalid, 2'b00);
    check("t1_ocredit", ocredit, 2'b01);
    check("t1_oreq_idle", oreq, 2'b00);
    cycle(0, 0, 0, 2'b00);
    check("t1_ocredit_end", ocredit, 2'b00);

    // 2: H,B,B,T on VC1 granted after arrival
    cred_cnt[1] = 0;
    cycle(1, 1, 32'h1111_1100, 2'b00);
    check("t2_oreq_route", oreq, 2'b10);
    cycle(1, 1, 32'h2222_2201, 2'b10);
    check("t2_oreq_active", oreq, 2'b00);
    cycle(1, 1, 32'h3333_3301, 2'b10);
    cycle(1, 1, 32'h4444_4402, 2'b10);
    cycle(0, 1, 0, 2'b10);
    cycle(0, 1, 0, 2'b00);
    check("t2_credits", cred_cnt[1], 4);
    check("t2_ovalid", ovalid, 2'b00);

    // 3: overflow, then full write with simultaneous pop
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 32'hC000_0003 | (i << 8), 2'b00);
    check("t3_ovf", ovf, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 2'b01);
    check("t3_no_fifth", ovalid[0], 0);
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 32'hD000_0003 | (i << 8), 2'b00);
    cycle(1, 0, 32'hD000_0F03, 2'b01);
    check("t3_full_rw", ovalid[0], 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 2'b01);
    do_reset();
    check("t3_ovf_clr", ovf, 0);

    // 4: alternate VC writes with grt=10 held
    for (int i = 0; i < 8; i++)
      cycle(1, i % 2, 32'hE000_0003 | (i << 8), 2'b10);
    cycle(0, 0, 0, 2'b10);
    check("t4_ovalid", ovalid, 2'b01);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 2'b01);

    // 5: ten flits through VC0, pop per cycle
    do_reset();
    cred_cnt[0] = 0;
    cycle(1, 0, 32'hF000_0003, 2'b00);
    for (int i = 1; i < 10; i++)
      cycle(1, 0, 32'hF000_0003 | (i << 8), 2'b01);
    cycle(0, 0, 0, 2'b01);
    cycle(0, 0, 0, 2'b00);
    check("t5_credits", cred_cnt[0], 10);

    // 6: reset mid-packet
    cycle(1, 1, 32'hAB00_0000, 2'b00);
    cycle(1, 1, 32'hAB00_0101, 2'b00);
    cycle(1, 1, 32'hAB00_0201, 2'b00);
    cycle(0, 1, 0, 2'b10);
    check("t6_active", {ovalid[1], oreq[1]}, 2'b10);
    do_reset();

    // random legal packet traffic
    for (int n = 0; n < 3000; n++) begin
      g  = 2'($urandom_range(0, 3));
      ch = $urandom_range(0, 1);
      iv = ($urandom_range(0, 2) != 0);
      if (iv && mq[ch].size() == DEPTH && !g[ch]) iv = 1'b0;
      d = '0;
      if (iv) gen_flit(ch, d);
      cycle(iv, ch, d, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
